// File: rtl/trig_stamp_if.sv
// Readout handshake between trig_stamp (master) and the CPU readout side (slave).
interface trig_stamp_if;
  logic [47:0] rec_data;
  logic        rec_valid;
  logic        rec_ready;

  modport master (output rec_data, output rec_valid, input rec_ready);
  modport slave  (input rec_data, input rec_valid, output rec_ready);
endinterface

// File: rtl/trig_stamp.sv
// Trigger/cycle time-stamper: builds 48-bit records per pulse into a FIFO drained via valid/ready.
// Optional TRIGSTAMP_OVFMARK_EN: after a drop, a type-11 overflow marker is queued ahead of new events.
module trig_stamp #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  trigpulse,
  input  logic                  cyclebegin,
  input  logic                  cycleend,
  input  logic                  clr_ovf,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic [15:0]           lostcnt,
  output logic                  overflow,
  trig_stamp_if.master          rdout
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef logic [DEPTH_LOG2:0] cnt_t;
  localparam cnt_t FULL = cnt_t'(DEPTH);

  logic [31:0]           tcnt_q, tcnt;
  logic [13:0]           evnum, cycnum;
  logic [47:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, rd_next;
  logic                  full, pop, wr, trig_acc, mark_wr, mark_req;
  logic [1:0]            nev, ndrop;
  logic [47:0]           wdata;
  logic [15:0]           lost_base;
  logic [16:0]           lost_sum;
  cnt_t                  avail;

`ifdef TRIGSTAMP_OVFMARK_EN
  logic mark_pend;
  assign mark_req = mark_pend;
`else
  assign mark_req = 1'b0;
`endif

  // tcnt counts clks since the begin pulse: 0 in the pulse clk itself, 1 in the next.
  assign tcnt      = cyclebegin ? '0 : tcnt_q;
  assign full      = (fifo_count == FULL);
  assign pop       = rdout.rec_valid & rdout.rec_ready;
  assign rd_next   = rd_ptr + DEPTH_LOG2'(pop);
  assign avail     = fifo_count - cnt_t'(pop);
  assign nev       = 2'(enable & cyclebegin) + 2'(enable & cycleend) + 2'(enable & trigpulse);
  assign ndrop     = nev - 2'(wr & ~mark_wr);
  assign lost_base = clr_ovf ? '0 : lostcnt;
  assign lost_sum  = {1'b0, lost_base} + 17'(ndrop);

  always_comb begin
    wr       = 1'b0;
    mark_wr  = 1'b0;
    trig_acc = 1'b0;
    wdata    = '0;
    if (!full) begin
      if (mark_req) begin
        wr      = 1'b1;
        mark_wr = 1'b1;
        wdata   = {2'b11, lostcnt[13:0], tcnt};
      end else if (enable && cyclebegin) begin
        wr    = 1'b1;
        wdata = {2'b01, cycnum + 14'd1, 32'd0};
      end else if (enable && cycleend) begin
        wr    = 1'b1;
        wdata = {2'b10, cycnum, tcnt};
      end else if (enable && trigpulse) begin
        wr       = 1'b1;
        trig_acc = 1'b1;
        wdata    = {2'b00, evnum, tcnt};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tcnt_q          <= '0;
      evnum           <= '0;
      cycnum          <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_count      <= '0;
      lostcnt         <= '0;
      overflow        <= 1'b0;
      rdout.rec_valid <= 1'b0;
      rdout.rec_data  <= '0;
`ifdef TRIGSTAMP_OVFMARK_EN
      mark_pend       <= 1'b0;
`endif
    end else begin
      tcnt_q     <= cyclebegin ? 32'd1 : ((tcnt_q == 32'hFFFF_FFFF) ? tcnt_q : tcnt_q + 32'd1);
      cycnum     <= cycnum + 14'(cyclebegin);
      evnum      <= cyclebegin ? '0 : evnum + 14'(trig_acc);
      wr_ptr     <= wr_ptr + DEPTH_LOG2'(wr);
      rd_ptr     <= rd_next;
      fifo_count <= fifo_count + cnt_t'(wr) - cnt_t'(pop);
      lostcnt    <= lost_sum[16] ? 16'hFFFF : lost_sum[15:0];
      overflow   <= (overflow & ~clr_ovf) | (ndrop != 2'd0);
      // Output register follows the entry behind the one being popped, giving 1 record/clk.
      rdout.rec_valid <= (avail != '0);
      if (avail != '0) rdout.rec_data <= mem[rd_next];
`ifdef TRIGSTAMP_OVFMARK_EN
      mark_pend <= (ndrop != 2'd0) | (mark_pend & ~mark_wr);
`endif
    end
  end
endmodule

// File: tb/tb_trig_stamp.sv
// Directed bench for trig_stamp: per-clk vector table plus hand-written multi-clk sequences.
module tb_trig_stamp;
  logic        clk = 1'b0;
  logic        rst_n, enable, trigpulse, cyclebegin, cycleend, clr_ovf;
  logic [4:0]  fifo_count;
  logic [15:0] lostcnt;
  logic        overflow;
  int          passed = 0, total = 0;

  trig_stamp_if rif();

  trig_stamp #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .trigpulse(trigpulse),
    .cyclebegin(cyclebegin), .cycleend(cycleend), .clr_ovf(clr_ovf),
    .fifo_count(fifo_count), .lostcnt(lostcnt), .overflow(overflow), .rdout(rif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en, tp, cb, ce, rdy;
    logic vld;
    logic [47:0] dat;
    int cnt;
  } vec_t;

  vec_t        vt[13];
  logic [47:0] q[$];
  logic        mon_en = 1'b0;
  logic        pv = 1'b0, pr = 1'b0;
  logic [47:0] pd = '0;
  int          unstable = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rif.rec_valid && rif.rec_ready) q.push_back(rif.rec_data);
      if (pv && !pr && (!rif.rec_valid || rif.rec_data != pd)) unstable++;
    end
    pv = rif.rec_valid;
    pr = rif.rec_ready;
    pd = rif.rec_data;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [47:0] rec(logic [1:0] t, logic [13:0] n, logic [31:0] tm);
    return {t, n, tm};
  endfunction

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_r();
    tick();
    rif.rec_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b1; trigpulse = 1'b0; cyclebegin = 1'b0;
    cycleend = 1'b0; clr_ovf = 1'b0; rif.rec_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic read_rec(output logic [47:0] d, output bit ok);
    ok = 1'b0; d = '0; rif.rec_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (rif.rec_valid) begin
        d = rif.rec_data; ok = 1'b1; tick();
        break;
      end
      tick();
    end
  endtask

  task automatic exp_rec(string nm, logic [47:0] e);
    logic [47:0] d; bit ok;
    read_rec(d, ok);
    chk({nm, "_ok"}, 64'(ok), 64'd1);
    chk(nm, d, e);
  endtask

  initial begin
    logic [47:0] d;
    bit ok;
    int errs;

    // reset state
    do_reset();
    chk("rst_valid", rif.rec_valid, 0);
    chk("rst_data", rif.rec_data, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_lost", lostcnt, 0);
    chk("rst_ovf", overflow, 0);

    // per-clk vectors starting from the first clk after reset (tcnt = row index)
    vt[0]  = '{1, 0, 1, 0, 1, 0, 48'h0, 1};
    vt[1]  = '{1, 1, 0, 0, 1, 1, rec(1, 1, 0), 2};
    vt[2]  = '{1, 0, 0, 0, 1, 1, rec(0, 0, 1), 1};
    vt[3]  = '{1, 0, 0, 1, 1, 0, rec(0, 0, 1), 1};
    vt[4]  = '{1, 0, 0, 0, 1, 1, rec(2, 1, 3), 1};
    vt[5]  = '{0, 1, 0, 0, 1, 0, rec(2, 1, 3), 0};
    vt[6]  = '{1, 1, 0, 0, 0, 0, rec(2, 1, 3), 1};
    vt[7]  = '{1, 1, 0, 0, 0, 1, rec(0, 1, 6), 2};
    vt[8]  = '{1, 0, 0, 0, 0, 1, rec(0, 1, 6), 2};
    vt[9]  = '{1, 0, 0, 0, 1, 1, rec(0, 2, 7), 1};
    vt[10] = '{1, 0, 0, 1, 1, 0, rec(0, 2, 7), 1};
    vt[11] = '{1, 0, 0, 0, 1, 1, rec(2, 1, 10), 1};
    vt[12] = '{1, 0, 0, 0, 1, 0, rec(2, 1, 10), 0};
    for (int i = 0; i < 13; i++) begin
      enable = vt[i].en; trigpulse = vt[i].tp; cyclebegin = vt[i].cb;
      cycleend = vt[i].ce; rif.rec_ready = vt[i].rdy;
      tick();
      chk($sformatf("vec%0d_vld", i), rif.rec_valid, vt[i].vld);
      chk($sformatf("vec%0d_dat", i), rif.rec_data, vt[i].dat);
      chk($sformatf("vec%0d_cnt", i), fifo_count, 64'(vt[i].cnt));
    end
    chk("vec_lost", lostcnt, 0);

    // single trigger 100 clk after a cycle begin
    do_reset();
    rif.rec_ready = 1'b1;
    repeat (9) tick();
    cyclebegin = 1'b1; tick(); cyclebegin = 1'b0;
    chk("t1_cb_count", fifo_count, 1);
    chk("t1_cb_vld0", rif.rec_valid, 0);
    tick();
    chk("t1_cb_vld1", rif.rec_valid, 1);
    chk("t1_cb_data", rif.rec_data, rec(1, 1, 0));
    repeat (98) tick();
    trigpulse = 1'b1; tick(); trigpulse = 1'b0;
    chk("t1_tr_vld0", rif.rec_valid, 0);
    tick();
    chk("t1_tr_vld1", rif.rec_valid, 1);
    chk("t1_tr_data", rif.rec_data, rec(0, 0, 100));

    // begin and trigger in the same clk
    do_reset();
    cyclebegin = 1'b1; trigpulse = 1'b1; tick(); cyclebegin = 1'b0; trigpulse = 1'b0;
    chk("col_count", fifo_count, 1);
    chk("col_lost", lostcnt, 1);
    chk("col_ovf", overflow, 1);
    tick();
`ifdef TRIGSTAMP_OVFMARK_EN
    chk("col_count_mark", fifo_count, 2);
`else
    chk("col_count_mark", fifo_count, 1);
`endif
    trigpulse = 1'b1; tick(); trigpulse = 1'b0;
    exp_rec("col_rec_cb", rec(1, 1, 0));
`ifdef TRIGSTAMP_OVFMARK_EN
    exp_rec("col_rec_mark", rec(3, 1, 1));
`endif
    exp_rec("col_rec_trig", rec(0, 0, 2));
    chk("col_lost_after", lostcnt, 1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("clr_lost", lostcnt, 0);
    chk("clr_ovf", overflow, 0);

    // overflow: 20 back-to-back triggers with no readout
    do_reset();
    trigpulse = 1'b1; repeat (20) tick(); trigpulse = 1'b0;
    chk("ovf_count", fifo_count, 16);
    chk("ovf_lost", lostcnt, 4);
    chk("ovf_flag", overflow, 1);
    for (int i = 0; i < 16; i++) exp_rec($sformatf("ovf_rec%0d", i), rec(0, 14'(i), 32'(i)));
    read_rec(d, ok);
`ifdef TRIGSTAMP_OVFMARK_EN
    chk("ovf_mark_ok", 64'(ok), 1);
    chk("ovf_mark_type", d[47:46], 3);
    chk("ovf_mark_num", d[45:32], 4);
`else
    chk("ovf_no_17th", 64'(ok), 0);
`endif
    trigpulse = 1'b1; tick(); trigpulse = 1'b0;
    read_rec(d, ok);
    chk("ovf_next_ok", 64'(ok), 1);
    chk("ovf_next_num", d[45:32], 16);

    // event-number wrap with a trigger every clk
    do_reset();
    q.delete(); mon_en = 1'b1; rif.rec_ready = 1'b1;
    cyclebegin = 1'b1; tick(); cyclebegin = 1'b0;
    trigpulse = 1'b1; repeat (16385) tick(); trigpulse = 1'b0;
    repeat (10) tick();
    mon_en = 1'b0;
    chk("wrap_len", q.size(), 16386);
    errs = 0;
    if (q.size() == 16386) begin
      if (q[0] != rec(1, 1, 0)) errs++;
      for (int i = 0; i < 16385; i++)
        if (q[i+1] != rec(0, 14'(i), 32'(i + 1))) errs++;
      chk("wrap_max", q[16384][45:32], 14'h3FFF);
      chk("wrap_zero", q[16385][45:32], 0);
    end
    chk("wrap_seq_errs", errs, 0);
    chk("wrap_lost", lostcnt, 0);

    // random backpressure over 100 triggers
    do_reset();
    q.delete(); unstable = 0; mon_en = 1'b1;
    cyclebegin = 1'b1; tick_r(); cyclebegin = 1'b0;
    for (int k = 0; k < 100; k++) begin
      trigpulse = 1'b1; tick_r(); trigpulse = 1'b0;
      repeat (4) tick_r();
    end
    rif.rec_ready = 1'b1;
    repeat (40) tick();
    mon_en = 1'b0;
    chk("bp_len", q.size(), 101);
    errs = 0;
    if (q.size() == 101)
      for (int k = 0; k < 100; k++)
        if (q[k+1] != rec(0, 14'(k), 32'(1 + 5 * k))) errs++;
    chk("bp_order_errs", errs, 0);
    chk("bp_unstable", unstable, 0);
    chk("bp_lost", lostcnt, 0);

    // reset mid-run with 8 records stored
    do_reset();
    trigpulse = 1'b1; repeat (8) tick(); trigpulse = 1'b0;
    chk("mr_count8", fifo_count, 8);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("mr_count0", fifo_count, 0);
    chk("mr_vld0", rif.rec_valid, 0);
    chk("mr_data0", rif.rec_data, 0);
    trigpulse = 1'b1; tick(); trigpulse = 1'b0;
    exp_rec("mr_next", rec(0, 0, 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
